// File: rtl/des_pkg.sv
// DES decryption constants: expansion, permutation, PC-2 and S-box tables,
// the reverse key-rotation schedule, and the iterative core's FSM state type.
package des_pkg;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

  localparam logic [5:0] E_TAB [0:47] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam logic [5:0] P_TAB [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam logic [5:0] PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Indexed by {row, col} = {b1, b6, b2..b5} of each 6-bit group.
  localparam logic [3:0] SBOX [0:7][0:63] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,   0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,  15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,   3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,  13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,   1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,  13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,   3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,  14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,  11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,  10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,   4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,  13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,   6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,   1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,   2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // Right-rotate amount applied before the round at index rnd (round 1 uses C0/D0 as-is).
  localparam logic [1:0] ROT_SCHED [0:15] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [1:28] rot_right(input logic [1:28] v, input logic [1:0] n);
    case (n)
      2'd1:    return {v[28], v[1:27]};
      2'd2:    return {v[27:28], v[1:26]};
      default: return v;
    endcase
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] k;
    k = '0;
    for (int i = 0; i < 48; i++) k[i+1] = cd[PC2_TAB[i]];
    return k;
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R, K): expansion, key mix, S-box substitution, permutation.
// Purely combinational, zero latency, no flow control.
module des_f
  import des_pkg::*;
(
  input  logic [1:32] r_i,
  input  logic [1:48] k_i,
  output logic [1:32] f_o
);

  logic [1:48] x;
  logic [1:32] s;
  logic [3:0]  sv;

  always_comb begin
    x   = '0;
    s   = '0;
    sv  = '0;
    f_o = '0;
    for (int i = 0; i < 48; i++) x[i+1] = r_i[E_TAB[i]] ^ k_i[i+1];
    for (int b = 0; b < 8; b++) begin
      sv = SBOX[b][{x[6*b+1], x[6*b+6], x[6*b+2], x[6*b+3], x[6*b+4], x[6*b+5]}];
      s[4*b+1] = sv[3];
      s[4*b+2] = sv[2];
      s[4*b+3] = sv[1];
      s[4*b+4] = sv[0];
    end
    for (int i = 0; i < 32; i++) f_o[i+1] = s[P_TAB[i]];
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core: one round per clock, out_valid 16 cycles after accept.
// Accepts only in IDLE; result held in DONE until out_ready, then IDLE (18-cycle minimum period).
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] in_block,
  input  logic [1:56] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] out_block
);

  state_e      state_q;
  logic [1:32] l_q, r_q, r_d, f_out;
  logic [1:28] c_q, d_q, c_d, d_d;
  logic [3:0]  rnd_q;
  logic        in_ready_q, out_valid_q;
  logic [1:64] out_q;
  logic [1:48] k_rnd;

  // Decrypt subkeys are derived by rotating the stored halves right before each round.
  assign c_d   = rot_right(c_q, ROT_SCHED[rnd_q]);
  assign d_d   = rot_right(d_q, ROT_SCHED[rnd_q]);
  assign k_rnd = pc2({c_d, d_d});

  des_f u_f (
    .r_i (r_q),
    .k_i (k_rnd),
    .f_o (f_out)
  );

  assign r_d = l_q ^ f_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            l_q        <= in_block[1:32];
            r_q        <= in_block[33:64];
            c_q        <= key_in[1:28];
            d_q        <= key_in[29:56];
            rnd_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          l_q   <= r_q;
          r_q   <= r_d;
          c_q   <= c_d;
          d_q   <= d_d;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd15) begin
            out_q       <= {r_d, r_q};
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = out_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed-vector bench for des_decrypt_iter with a queue scoreboard and independent output monitor.
module tb_des_decrypt_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:64] in_block;
  logic [1:56] key_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:64] out_block;

  des_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] key;
    logic [63:0] pt;
    logic [63:0] ct;
  } vec_t;

  localparam vec_t VECS [0:5] = '{
    '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405},
    '{64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000},
    '{64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7},
    '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58},
    '{64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815},
    '{64'h1111111111111111, 64'h1111111111111111, 64'hF40379AB9E0EC533}};

  localparam logic [6:0] IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam logic [6:0] FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam logic [6:0] PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  function automatic logic [1:64] ip_f(input logic [1:64] v);
    logic [1:64] o;
    for (int i = 0; i < 64; i++) o[i+1] = v[IP_T[i]];
    return o;
  endfunction

  function automatic logic [1:64] fp_f(input logic [1:64] v);
    logic [1:64] o;
    for (int i = 0; i < 64; i++) o[i+1] = v[FP_T[i]];
    return o;
  endfunction

  function automatic logic [1:56] pc1_f(input logic [1:64] v);
    logic [1:56] o;
    for (int i = 0; i < 56; i++) o[i+1] = v[PC1_T[i]];
    return o;
  endfunction

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every completed output handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", fp_f(out_block));
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", fp_f(out_block), mon_exp);
      end
    end
  end

  // acc is the bench cycle count just after the accept edge.
  task automatic issue(input int v, output int acc, output int waited);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=<100", waited);
    end
    in_block = ip_f(VECS[v].ct);
    key_in   = pc1_f(VECS[v].key);
    in_valid = 1'b1;
    acc      = cyc + 1;
    exp_q.push_back(VECS[v].pt);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input int acc, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s out_valid_timeout actual=0 required=1", nm);
    end else begin
      chk(nm, 64'(cyc - acc), 64'd16);
    end
  endtask

  int acc, waited;
  int accs [0:3];

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_block  = '0;
    key_in    = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_block", 64'(out_block), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready",  64'(in_ready),  64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Known vectors, consumer always ready.
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      issue(v, acc, waited);
      wait_out(acc, "latency_vec");
    end

    // Backpressure: result held for 10+ cycles in DONE.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(2, acc, waited);
    wait_out(acc, "latency_bp");
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_block", 64'(out_block), 64'(ip_f(VECS[2].pt)));
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready",  64'(in_ready),  64'd1);

    // Busy rejection: foreign data pulsed during RUN must not disturb the job.
    issue(3, acc, waited);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1;
    in_block = ip_f(VECS[4].ct);
    key_in   = pc1_f(VECS[4].key);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 in_valid = 1'b1;
    in_block = ip_f(VECS[5].ct);
    key_in   = pc1_f(VECS[5].key);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(acc, "latency_busy");

    // Reset abort in the middle of RUN.
    issue(4, acc, waited);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_block", 64'(out_block), 64'd0);
    chk("abort_in_ready",  64'(in_ready),  64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(5, acc, waited);
    chk("abort_first_accept_wait", 64'(waited), 64'd0);
    wait_out(acc, "latency_after_abort");

    // Back-to-back with in_valid and out_ready held high.
    for (int j = 0; j < 4; j++) begin
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      in_block = ip_f(VECS[j].ct);
      key_in   = pc1_f(VECS[j].key);
      in_valid = 1'b1;
      accs[j]  = cyc + 1;
      exp_q.push_back(VECS[j].pt);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    for (int j = 1; j < 4; j++) chk("b2b_spacing", 64'(accs[j] - accs[j-1]), 64'd18);
    wait_out(accs[3], "latency_b2b_last");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
